// File: rtl/dma_axi_simple_sched_if.sv
// Requester, completion and DMA-core signal bundle for dma_axi_simple_sched.
// master: scheduler side. slave: requesters plus DMA core.
interface dma_axi_simple_sched_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
);
    logic                   SCHED_EN;
    logic [NUM_CH-1:0]      REQ_VLD;
    logic [NUM_CH-1:0]      REQ_RDY;
    logic [32*NUM_CH-1:0]   REQ_SRC;
    logic [32*NUM_CH-1:0]   REQ_DST;
    logic [16*NUM_CH-1:0]   REQ_BNUM;
    logic [8*NUM_CH-1:0]    REQ_CHUNK;
    logic [NUM_CH-1:0]      CMP_VLD;
    logic                   CMP_ERR;
    logic                   SCHED_BUSY;
    logic [CH_W-1:0]        SCHED_CH;
    logic                   DMA_EN;
    logic                   DMA_GO;
    logic                   DMA_BUSY;
    logic                   DMA_DONE;
    logic [31:0]            DMA_SRC;
    logic [31:0]            DMA_DST;
    logic [15:0]            DMA_BNUM;
    logic [7:0]             DMA_CHUNK;

    modport master (
        input  SCHED_EN, REQ_VLD, REQ_SRC, REQ_DST, REQ_BNUM, REQ_CHUNK,
        input  DMA_BUSY, DMA_DONE,
        output REQ_RDY, CMP_VLD, CMP_ERR, SCHED_BUSY, SCHED_CH,
        output DMA_EN, DMA_GO, DMA_SRC, DMA_DST, DMA_BNUM, DMA_CHUNK
    );

    modport slave (
        output SCHED_EN, REQ_VLD, REQ_SRC, REQ_DST, REQ_BNUM, REQ_CHUNK,
        output DMA_BUSY, DMA_DONE,
        input  REQ_RDY, CMP_VLD, CMP_ERR, SCHED_BUSY, SCHED_CH,
        input  DMA_EN, DMA_GO, DMA_SRC, DMA_DST, DMA_BNUM, DMA_CHUNK
    );
endinterface

// File: rtl/dma_axi_simple_sched.sv
// Round-robin job scheduler sharing one simple DMA core among NUM_CH requesters.
// Optional watchdog/abort path enabled by defining DMA_SCHED_TIMEOUT_EN.
module dma_axi_simple_sched #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CH_W    = $clog2(NUM_CH),
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic                      ARESETn,
    input  logic                      ACLK,
    dma_axi_simple_sched_if.master    bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_REL,
        S_CMPL
`ifdef DMA_SCHED_TIMEOUT_EN
        ,
        S_ABORT
`endif
    } state_t;

    state_t              r_state;
    logic [CH_W-1:0]     r_last;
    logic [CH_W-1:0]     r_ch;
    logic [NUM_CH-1:0]   r_oh;
    logic [NUM_CH-1:0]   r_cmp_vld;
    logic                r_busy;
    logic                r_en;
    logic                r_go;
    logic [31:0]         r_src;
    logic [31:0]         r_dst;
    logic [15:0]         r_bnum;
    logic [7:0]          r_chunk;
`ifdef DMA_SCHED_TIMEOUT_EN
    logic                r_cmp_err;
    logic [15:0]         r_wdog;
`endif

    logic                w_take;
    logic [CH_W-1:0]     w_gnt;
    logic [NUM_CH-1:0]   w_sel;
    logic [31:0]         w_src;
    logic [31:0]         w_dst;
    logic [15:0]         w_bnum;
    logic [7:0]          w_chunk;

    // Winner is the valid channel with the smallest forward distance from last+1.
    always_comb begin : grant_sel
        int unsigned w_dist;
        int unsigned w_best;
        w_dist  = 0;
        w_best  = NUM_CH;
        w_gnt   = '0;
        w_sel   = '0;
        w_src   = '0;
        w_dst   = '0;
        w_bnum  = '0;
        w_chunk = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_dist = (k + NUM_CH - 1 - 32'(r_last)) % NUM_CH;
            if (bus.REQ_VLD[k] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_gnt    = CH_W'(k);
                w_sel    = '0;
                w_sel[k] = 1'b1;
                w_src    = bus.REQ_SRC[k*32 +: 32];
                w_dst    = bus.REQ_DST[k*32 +: 32];
                w_bnum   = bus.REQ_BNUM[k*16 +: 16];
                w_chunk  = bus.REQ_CHUNK[k*8 +: 8];
            end
        end
    end

    assign w_take      = (r_state == S_IDLE) && bus.SCHED_EN && (|bus.REQ_VLD);
    assign bus.REQ_RDY = w_take ? w_sel : '0;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= S_IDLE;
            r_last    <= CH_W'(NUM_CH - 1);
            r_ch      <= '0;
            r_oh      <= '0;
            r_cmp_vld <= '0;
            r_busy    <= 1'b0;
            r_en      <= 1'b0;
            r_go      <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_bnum    <= '0;
            r_chunk   <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
            r_cmp_err <= 1'b0;
            r_wdog    <= '0;
`endif
        end else begin
            r_cmp_vld <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
            r_cmp_err <= 1'b0;
`endif
            unique case (r_state)
                S_IDLE: begin
                    r_en <= 1'b0;
                    r_go <= 1'b0;
                    if (w_take) begin
                        r_last  <= w_gnt;
                        r_ch    <= w_gnt;
                        r_oh    <= w_sel;
                        r_src   <= w_src;
                        r_dst   <= w_dst;
                        r_bnum  <= w_bnum;
                        r_chunk <= w_chunk;
                        r_busy  <= 1'b1;
                        if (w_bnum == '0) begin
                            r_state   <= S_CMPL;
                            r_cmp_vld <= w_sel;
                        end else begin
                            r_state <= S_SETUP;
                            r_en    <= 1'b1;
`ifdef DMA_SCHED_TIMEOUT_EN
                            r_wdog  <= '0;
`endif
                        end
                    end
                end
                S_SETUP: begin
                    r_state <= S_RUN;
                    r_go    <= 1'b1;
                end
                S_RUN: begin
`ifdef DMA_SCHED_TIMEOUT_EN
                    if (r_wdog == TIMEOUT) begin
                        r_state <= S_ABORT;
                        r_en    <= 1'b0;
                        r_go    <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                        if (bus.DMA_DONE) begin
                            r_state <= S_REL;
                            r_go    <= 1'b0;
                        end
                    end
`else
                    if (bus.DMA_DONE) begin
                        r_state <= S_REL;
                        r_go    <= 1'b0;
                    end
`endif
                end
                S_REL: begin
`ifdef DMA_SCHED_TIMEOUT_EN
                    if (r_wdog == TIMEOUT) begin
                        r_state <= S_ABORT;
                        r_en    <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                        if (!bus.DMA_DONE && !bus.DMA_BUSY) begin
                            r_state   <= S_CMPL;
                            r_en      <= 1'b0;
                            r_cmp_vld <= r_oh;
                        end
                    end
`else
                    if (!bus.DMA_DONE && !bus.DMA_BUSY) begin
                        r_state   <= S_CMPL;
                        r_en      <= 1'b0;
                        r_cmp_vld <= r_oh;
                    end
`endif
                end
`ifdef DMA_SCHED_TIMEOUT_EN
                S_ABORT: begin
                    r_state   <= S_CMPL;
                    r_cmp_vld <= r_oh;
                    r_cmp_err <= 1'b1;
                end
`endif
                S_CMPL: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                    r_go    <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                    r_go    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CMP_VLD    = r_cmp_vld;
    assign bus.SCHED_BUSY = r_busy;
    assign bus.SCHED_CH   = r_ch;
    assign bus.DMA_EN     = r_en;
    assign bus.DMA_GO     = r_go;
    assign bus.DMA_SRC    = r_src;
    assign bus.DMA_DST    = r_dst;
    assign bus.DMA_BNUM   = r_bnum;
    assign bus.DMA_CHUNK  = r_chunk;

`ifdef DMA_SCHED_TIMEOUT_EN
    assign bus.CMP_ERR = r_cmp_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign bus.CMP_ERR      = 1'b0;
`endif
endmodule

// File: doc/dma_axi_simple_sched.md
# dma_axi_simple_sched

Multi-channel job scheduler that shares one simple AXI DMA core (the `DMA_EN`/`DMA_GO`/`DMA_BUSY`/`DMA_DONE` register-level interface) among `NUM_CH` requesters. Each requester presents a descriptor with source, destination, byte count and chunk size. The block grants requesters round-robin, loads the winning descriptor into the core, sequences the enable/go handshake, waits for completion, and returns a per-channel completion pulse. It sits between the register/CSR front-end (or hardware requesters) and the DMA core.

## Interface
Parameters:
- `NUM_CH`, 4: number of requesting channels, 2..8.
- `CH_W`, clogb2(NUM_CH): width of the channel index.
- `TIMEOUT`, 16'hFFFF: watchdog limit in cycles. Used only when `DMA_SCHED_TIMEOUT_EN` is defined.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low, named `ACLK` and `ARESETn`.
- `ARESETn`  in  1  async active-low reset
- `ACLK`  in  1  clock
- `SCHED_EN`  in  1  global enable; gates new grants only
- `REQ_VLD`  in  NUM_CH  per-channel descriptor valid
- `REQ_RDY`  out  NUM_CH  per-channel accept; one-hot or zero
- `REQ_SRC`  in  32*NUM_CH  source addresses, channel n at [32n+31:32n]
- `REQ_DST`  in  32*NUM_CH  destination addresses
- `REQ_BNUM`  in  16*NUM_CH  byte counts
- `REQ_CHUNK`  in  8*NUM_CH  chunk sizes
- `CMP_VLD`  out  NUM_CH  one-cycle completion pulse, one-hot
- `CMP_ERR`  out  1  qualifies `CMP_VLD`; 1 means the job was aborted
- `SCHED_BUSY`  out  1  high in every state except IDLE
- `SCHED_CH`  out  CH_W  channel currently owning the core
- `DMA_EN`  out  1  core enable; low clears the core FIFO
- `DMA_GO`  out  1  core start
- `DMA_BUSY`  in  1  core busy
- `DMA_DONE`  in  1  core done
- `DMA_SRC`, `DMA_DST`  out  32  registered descriptor
- `DMA_BNUM`  out  16  registered descriptor
- `DMA_CHUNK`  out  8  registered descriptor

## Operation
- States: IDLE, SETUP, RUN, REL, CMPL, and ABORT (ABORT exists only with the macro).
- IDLE:
  - When `SCHED_EN` is high and any `REQ_VLD` bit is set, grant the first set bit searching upward from `last+1`, wrapping modulo NUM_CH.
  - In the same cycle: assert `REQ_RDY[g]` combinationally, capture the descriptor into the `DMA_*` registers, set `SCHED_CH=g` and `last=g`.
  - If `BNUM==0`, go to CMPL without touching the core. Otherwise go to SETUP.
- SETUP: `DMA_EN=1`, `DMA_GO=0` for exactly one cycle, then go to RUN.
- RUN: `DMA_EN=1`, `DMA_GO=1`. Hold until `DMA_DONE==1`, then go to REL.
- REL: `DMA_GO=0`, `DMA_EN=1`. Wait until `DMA_DONE==0 && DMA_BUSY==0`, then go to CMPL.
- CMPL:
  - `CMP_VLD[SCHED_CH]=1` for one cycle; `CMP_ERR` is 1 if entered from ABORT, otherwise 0.
  - `DMA_EN=0`; return to IDLE.
- Round-robin pointer `last` resets to NUM_CH-1, so channel 0 wins first after reset.
- A channel that is granted must hold its descriptor stable only during its `REQ_RDY` cycle.
- `SCHED_EN` falling mid-job: the job completes normally and no further grants occur. `SCHED_EN` never aborts a job.
- Reset mid-job: all state and outputs return to reset values immediately. The core is not waited on; `DMA_EN=0` clears it.
- `REQ_VLD` may drop without being granted; that is not an error.

## Timing
- Reset values: `REQ_RDY=0`, `CMP_VLD=0`, `CMP_ERR=0`, `SCHED_BUSY=0`, `SCHED_CH=0`, `DMA_EN=0`, `DMA_GO=0`, and all `DMA_*` descriptor outputs 0.
- Accept happens at cycle 0. `DMA_EN` rises at cycle 1 and `DMA_GO` at cycle 2.
- `DMA_DONE` seen at cycle k drops `DMA_GO` at k+1.
- A zero-length job pulses `CMP_VLD` at cycle 1.
- `DMA_EN` is low for at least 2 cycles between consecutive jobs (CMPL, then IDLE), and the next `REQ_RDY` comes at the earliest in the IDLE cycle after CMPL.
- The descriptor outputs are stable from SETUP through CMPL.

## Configuration
- `DMA_SCHED_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to SETUP and increments in RUN and REL.
  - When it equals `TIMEOUT`, go to ABORT: `DMA_GO=0`, `DMA_EN=0` for one cycle, then go to CMPL with `CMP_ERR=1`.
  - The watchdog has priority when `DMA_DONE` arrives in the same cycle the limit is reached.
- Not defined: no counter and no ABORT state; `CMP_ERR` is tied to 0 and `TIMEOUT` is ignored.

## Test plan
- Single job on channel 0 (SRC=0x1000, DST=0x2000, BNUM=64, CHUNK=16), core model raises DONE 20 cycles after GO -> EN at cycle 1, GO at cycle 2, `CMP_VLD=4'b0001` exactly once, `CMP_ERR=0`.
- All four `REQ_VLD` held high continuously -> grant order 0,1,2,3,0, with one `CMP_VLD` per job in that same order.
- Channel 2 with BNUM=0 -> `REQ_RDY[2]` at cycle 0, `CMP_VLD[2]` at cycle 1, and `DMA_EN`/`DMA_GO` never rise.
- Core holds BUSY=1 for 3 cycles after DONE -> scheduler stays in REL and `CMP_VLD` is delayed until BUSY=0.
- With the macro and TIMEOUT=50, core never raises DONE -> abort at 50 cycles, `DMA_EN` drops, `CMP_VLD` with `CMP_ERR=1`. Without the macro the scheduler waits indefinitely.
- `ARESETn` asserted while in RUN -> `DMA_EN`/`DMA_GO` go to 0 asynchronously; after release, channel 0 is granted first.
